// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    DATA,
    CSUM
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream, payload, status and ack signals around the frame parser.
// Latency: n/a (wiring only).
// Backpressure: only the ack byte is flow-controlled (tx_data_vld/tx_ready).
interface uart_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_data_vld;
  logic       pl_vld;
  logic [7:0] pl_data;
  logic [7:0] pl_idx;
  logic       frame_done;
  logic       frame_ok;
  logic [7:0] frame_cmd;
  logic [7:0] frame_len;
  logic [1:0] err_code;
  logic [7:0] tx_data;
  logic       tx_data_vld;
  logic       tx_ready;

  // Environment side: feeds bytes, consumes results.
  modport master (
    output rx_data, rx_data_vld, tx_ready,
    input  pl_vld, pl_data, pl_idx, frame_done, frame_ok,
           frame_cmd, frame_len, err_code, tx_data, tx_data_vld
  );

  // Parser side.
  modport slave (
    input  rx_data, rx_data_vld, tx_ready,
    output pl_vld, pl_data, pl_idx, frame_done, frame_ok,
           frame_cmd, frame_len, err_code, tx_data, tx_data_vld
  );
endinterface

// File: rtl/uart_frame_parser_timeout.sv
// Inter-byte idle counter; flags expiry when a frame stalls too long.
// Latency: expire is combinational from the registered count.
// Backpressure: none; a kick in the expiry cycle suppresses expire.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic kick,
  output logic expire
);

  localparam int            W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  // Count idle cycles while inside a frame; clear on each byte, saturate at LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || kick) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = active && !kick && (cnt == LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HEADER/cmd/len/payload/checksum frames from the uart_rx byte stream.
// Latency: pl_vld and frame_done one cycle after the triggering rx_data_vld.
// Backpressure: none on input; ack byte (UART_FRAME_PARSER_ACK_EN) held until tx_ready.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 5_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_frame_parser_if.slave   bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] cnt_q, cnt_d;

  logic       pl_vld_d;
  logic [7:0] pl_data_d, pl_idx_d;
  logic       done_d, ok_d;
  logic [1:0] err_d;
  logic [7:0] fcmd_d, flen_d;
  logic       expire;

  uart_frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .active (state_q != IDLE),
    .kick   (bus.rx_data_vld),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, frame bookkeeping and next output values.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;
    pl_vld_d  = 1'b0;
    pl_data_d = bus.pl_data;
    pl_idx_d  = bus.pl_idx;
    done_d    = 1'b0;
    ok_d      = bus.frame_ok;
    err_d     = bus.err_code;
    fcmd_d    = bus.frame_cmd;
    flen_d    = bus.frame_len;

    if (expire) begin
      done_d  = 1'b1;
      ok_d    = 1'b0;
      err_d   = ERR_TIMEOUT;
      fcmd_d  = cmd_q;
      flen_d  = len_q;
      state_d = IDLE;
    end else if (bus.rx_data_vld) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == HEADER) begin
            state_d = CMD;
            cmd_d   = 8'h00;
            len_d   = 8'h00;
            csum_d  = 8'h00;
            cnt_d   = 8'h00;
          end
        end
        CMD: begin
          cmd_d   = bus.rx_data;
          csum_d  = bus.rx_data;
          state_d = LEN;
        end
        LEN: begin
          len_d  = bus.rx_data;
          csum_d = csum_q + bus.rx_data;
          cnt_d  = 8'h00;
          if (bus.rx_data > MAX_LEN_B) begin
            done_d  = 1'b1;
            ok_d    = 1'b0;
            err_d   = ERR_LEN;
            fcmd_d  = cmd_q;
            flen_d  = bus.rx_data;
            state_d = IDLE;
          end else if (bus.rx_data == 8'h00) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          pl_vld_d  = 1'b1;
          pl_data_d = bus.rx_data;
          pl_idx_d  = cnt_q;
          csum_d    = csum_q + bus.rx_data;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = CSUM;
        end
        CSUM: begin
          done_d  = 1'b1;
          fcmd_d  = cmd_q;
          flen_d  = len_q;
          state_d = IDLE;
          if (bus.rx_data == csum_q) begin
            ok_d  = 1'b1;
            err_d = ERR_NONE;
          end else begin
            ok_d  = 1'b0;
            err_d = ERR_CSUM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame bookkeeping registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q          <= 8'h00;
      len_q          <= 8'h00;
      csum_q         <= 8'h00;
      cnt_q          <= 8'h00;
      bus.pl_vld     <= 1'b0;
      bus.pl_data    <= 8'h00;
      bus.pl_idx     <= 8'h00;
      bus.frame_done <= 1'b0;
      bus.frame_ok   <= 1'b0;
      bus.err_code   <= ERR_NONE;
      bus.frame_cmd  <= 8'h00;
      bus.frame_len  <= 8'h00;
    end else begin
      cmd_q          <= cmd_d;
      len_q          <= len_d;
      csum_q         <= csum_d;
      cnt_q          <= cnt_d;
      bus.pl_vld     <= pl_vld_d;
      bus.pl_data    <= pl_data_d;
      bus.pl_idx     <= pl_idx_d;
      bus.frame_done <= done_d;
      bus.frame_ok   <= ok_d;
      bus.err_code   <= err_d;
      bus.frame_cmd  <= fcmd_d;
      bus.frame_len  <= flen_d;
    end
  end

`ifdef UART_FRAME_PARSER_ACK_EN
  // Ack/nak byte: loaded on every frame end (newest wins), dropped once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tx_data     <= 8'h00;
      bus.tx_data_vld <= 1'b0;
    end else if (done_d) begin
      bus.tx_data     <= ok_d ? ACK_BYTE : NAK_BYTE;
      bus.tx_data_vld <= 1'b1;
    end else if (bus.tx_data_vld && bus.tx_ready) begin
      bus.tx_data_vld <= 1'b0;
    end
  end
`else
  logic unused_tx_ready;
  assign unused_tx_ready = bus.tx_ready;
  assign bus.tx_data     = 8'h00;
  assign bus.tx_data_vld = 1'b0;
`endif

endmodule
